// File: rtl/mmio_store_fifo_if.sv
// Processor data-bus slice plus drain stream for the MMIO store FIFO.
// Signal names follow the single-cycle CPU datapath.
interface mmio_store_fifo_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport slave (
    input  MemWrite,
    input  ALUResult,
    input  WriteData,
    input  out_ready,
    output ReadData,
    output hit,
    output out_valid,
    output out_data
  );

  modport master (
    output MemWrite,
    output ALUResult,
    output WriteData,
    output out_ready,
    input  ReadData,
    input  hit,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/mmio_store_fifo.sv
// MMIO store FIFO: CPU stores push words, a valid/ready port drains them.
// Define MMIO_STORE_FIFO_TS_EN to add the free-running TS counter at offset 3.
module mmio_store_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input logic              clk,
  input logic              reset,
  mmio_store_fifo_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic        hit;
  logic [1:0]  off;
  logic        sel_data, sel_stat, sel_ctrl, sel_ts;
  logic        push, pop, accept;
  logic        ctrl_wr, flush, clr_ovf;
  logic        full, empty;
  logic [7:0]  cnt8;
  logic [31:0] status;
  logic [31:0] ts_val;
  logic [31:0] rdata;
  logic [1:0]  unused_addr;

  assign unused_addr = bus.ALUResult[1:0];

  always_comb begin
    hit      = (bus.ALUResult[31:4] == BASE_ADDR[31:4]);
    off      = bus.ALUResult[3:2];
    sel_data = hit & (off == 2'd0);
    sel_stat = hit & (off == 2'd1);
    sel_ctrl = hit & (off == 2'd2);
    sel_ts   = hit & (off == 2'd3);
  end

  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    push    = bus.MemWrite & sel_data;
    pop     = ~empty & bus.out_ready;
    // A full FIFO can still take a word if the head leaves this edge
    accept  = push & (~full | pop);
    ctrl_wr = bus.MemWrite & sel_ctrl;
    flush   = ctrl_wr & bus.WriteData[1];
    clr_ovf = ctrl_wr & bus.WriteData[0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (accept)
      wr_ptr_d = wr_ptr_q + AW'(1);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (push & ~accept)
      ovf_d = 1'b1;
    // Clear beats a drop recorded in the same cycle
    if (clr_ovf)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem_q[wr_ptr_q] <= bus.WriteData;
  end

`ifdef MMIO_STORE_FIFO_TS_EN
  logic [31:0] ts_q, ts_d;
  logic        ts_wr;

  always_comb begin
    ts_wr = bus.MemWrite & sel_ts;
    ts_d  = ts_wr ? bus.WriteData : ts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ts_q <= '0;
    else
      ts_q <= ts_d;
  end

  assign ts_val = ts_q;
`else
  assign ts_val = '0;
`endif

  always_comb begin
    cnt8   = 8'(count_q);
    status = {16'b0, cnt8, 5'b0, ovf_q, full, empty};
    rdata  = '0;
    unique case (1'b1)
      sel_stat: rdata = status;
      sel_ts:   rdata = ts_val;
      default:  rdata = '0;
    endcase
  end

  assign bus.hit       = hit;
  assign bus.ReadData  = rdata;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_mmio_store_fifo.sv
// Directed bench for mmio_store_fifo.
// Drained words are checked against a queue of accepted stores.
module tb_mmio_store_fifo;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;
  localparam logic [31:0] A_TS   = BASE + 32'd12;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] sb[$];
  logic [31:0] v;

  mmio_store_fifo_if bus ();

  mmio_store_fifo #(
    .DEPTH(8),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [31:0] a, output logic [31:0] rd);
    bus.ALUResult = a;
    #1;
    rd = bus.ReadData;
  endtask

  task automatic chk_stat(input string tag, input logic [31:0] exp);
    logic [31:0] r;
    ld(A_STAT, r);
    chk(tag, r, exp);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.ALUResult = a;
    bus.WriteData = d;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    st(A_DATA, d);
    sb.push_back(d);
  endtask

  task automatic drain(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        e = sb.pop_front();
        chk(tag, bus.out_data, e);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk({tag, "_left"}, 32'(sb.size()), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h0000_0040;
    bus.WriteData = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_stat("stat_in_reset", 32'h1);
    reset = 1'b0;
    @(negedge clk);

    ld(A_STAT, v);
    chk("stat_reset", v, 32'h1);
    chk("hit_in", 32'(bus.hit), 32'd1);
    chk("valid_reset", 32'(bus.out_valid), 32'd0);
    ld(32'h0000_0040, v);
    chk("hit_out", 32'(bus.hit), 32'd0);
    chk("rd_out", v, 32'd0);

    push_word(32'd24);
    chk("valid_24", 32'(bus.out_valid), 32'd1);
    chk("head_24", bus.out_data, sb[0]);
    chk_stat("stat_one", 32'h0000_0100);
    ld(A_DATA, v);
    chk("data_load", v, 32'd0);
    @(negedge clk);
    chk("no_pop_on_load", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    void'(sb.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_after_pop", 32'(bus.out_valid), 32'd0);
    chk_stat("stat_after_pop", 32'h1);

    for (int i = 1; i <= 8; i++) push_word(32'(i));
    chk_stat("stat_full", 32'h0000_0802);
    st(A_DATA, 32'd9);
    chk_stat("stat_ovf", 32'h0000_0806);
    st(A_STAT, 32'hFFFF_FFFF);
    chk_stat("stat_store_ign", 32'h0000_0806);
    drain("drain_1to8");
    chk_stat("stat_ovf_empty", 32'h0000_0005);
    st(A_CTRL, 32'd1);
    chk_stat("stat_clr", 32'h1);

    for (int i = 0; i < 8; i++) push_word(32'd100 + 32'(i));
    bus.out_ready = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.ALUResult = A_DATA;
    bus.WriteData = 32'd77;
    #1;
    chk("full_pop_head", bus.out_data, sb.pop_front());
    sb.push_back(32'd77);
    @(negedge clk);
    bus.MemWrite  = 1'b0;
    bus.out_ready = 1'b0;
    chk_stat("stat_full_pp", 32'h0000_0802);
    drain("drain_77");

    for (int i = 0; i < 3; i++) push_word(32'hA0 + 32'(i));
    chk_stat("stat_three", 32'h0000_0300);
    bus.out_ready = 1'b1;
    st(A_CTRL, 32'd2);
    bus.out_ready = 1'b0;
    sb.delete();
    chk("valid_flush", 32'(bus.out_valid), 32'd0);
    chk_stat("stat_flush", 32'h1);

    push_word(32'hC0);
    push_word(32'hC1);
    chk("head_post_flush", bus.out_data, sb[0]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("valid_mid_reset", 32'(bus.out_valid), 32'd0);
    chk_stat("stat_mid_reset", 32'h1);

`ifdef MMIO_STORE_FIFO_TS_EN
    st(A_TS, 32'hFFFF_FFFE);
    @(negedge clk);
    @(negedge clk);
    ld(A_TS, v);
    chk("ts_wrap", v, 32'd0);
    @(negedge clk);
    ld(A_TS, v);
    chk("ts_inc", v, 32'd1);
`else
    ld(A_TS, v);
    chk("ts_off", v, 32'd0);
    st(A_TS, 32'h1234_5678);
    ld(A_TS, v);
    chk("ts_off_st", v, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
